// File: rtl/bus_xfer_sequencer.sv
// Bus transfer sequencer: arbitrates the shared 8-bit off-chip bus between the
// PC/MAR/MDR shift registers and the host, moving each value as BYTES byte
// transfers with a four-phase ready handshake per byte.
module bus_xfer_sequencer #(
  parameter int BYTES   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ard_receive_ready,
  input  logic       ard_data_ready,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       busy,
  output logic       bus_pc,
  output logic       bus_mar,
  output logic       bus_mdr,
  output logic       pc_shift_out,
  output logic       mar_shift_out,
  output logic       mdr_shift_out,
  output logic       mdr_shift_in,
  output logic       byte_valid,
  output logic       byte_req,
  output logic       timeout_err
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;
  localparam bit               TMO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    DONE,
    ABORT
  } state_t;

  state_t           state, state_n;
  logic [3:0]       gnt_n;
  logic [CNT_W-1:0] byte_cnt, cnt_n;
  logic [TMR_W-1:0] timer, timer_n, timer_inc;
  logic             awaited;
  logic             expired;
  logic             live_n;

  // The inbound requester (mdr_in) listens to ard_data_ready, every outbound
  // requester listens to ard_receive_ready; the other ready is ignored.
  assign awaited   = gnt[3] ? ard_data_ready : ard_receive_ready;
  assign timer_inc = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
  assign expired   = TMO_EN && (timer == TMR_LIMIT);
  assign live_n    = (state_n == SETUP) || (state_n == STROBE) || (state_n == RELEASE);

  // Next-state logic: arbitration in IDLE, then the per-byte handshake with timeout.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = byte_cnt;
    timer_n = timer;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        timer_n = '0;
        if (req[1])      gnt_n = 4'b0010;
        else if (req[2]) gnt_n = 4'b0100;
        else if (req[3]) gnt_n = 4'b1000;
        else if (req[0]) gnt_n = 4'b0001;
        else             gnt_n = 4'b0000;
        if (req != 4'b0000) state_n = SETUP;
      end
      SETUP: begin
        if (awaited)      state_n = STROBE;
        else if (expired) state_n = ABORT;
        else              timer_n = timer_inc;
      end
      STROBE: begin
        state_n = RELEASE;
        timer_n = '0;
      end
      RELEASE: begin
        if (!awaited) begin
          if (byte_cnt == LAST_BYTE) begin
            state_n = DONE;
          end else begin
            cnt_n   = byte_cnt + CNT_W'(1);
            timer_n = '0;
            state_n = SETUP;
          end
        end else if (expired) begin
          state_n = ABORT;
        end else begin
          timer_n = timer_inc;
        end
      end
      DONE, ABORT: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  // State registers plus outputs registered from the next state, so every
  // output is a pure function of the registered state and grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      gnt           <= 4'b0000;
      byte_cnt      <= '0;
      timer         <= '0;
      done          <= 4'b0000;
      busy          <= 1'b0;
      bus_pc        <= 1'b0;
      bus_mar       <= 1'b0;
      bus_mdr       <= 1'b0;
      pc_shift_out  <= 1'b0;
      mar_shift_out <= 1'b0;
      mdr_shift_out <= 1'b0;
      mdr_shift_in  <= 1'b0;
      byte_valid    <= 1'b0;
      byte_req      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      gnt           <= gnt_n;
      byte_cnt      <= cnt_n;
      timer         <= timer_n;
      done          <= (state_n == DONE) ? gnt_n : 4'b0000;
      busy          <= (state_n != IDLE);
      bus_pc        <= live_n && gnt_n[0];
      bus_mar       <= live_n && gnt_n[1];
      bus_mdr       <= live_n && gnt_n[2];
      pc_shift_out  <= (state_n == STROBE) && gnt_n[0];
      mar_shift_out <= (state_n == STROBE) && gnt_n[1];
      mdr_shift_out <= (state_n == STROBE) && gnt_n[2];
      mdr_shift_in  <= (state_n == STROBE) && gnt_n[3];
      byte_valid    <= (state_n == SETUP) && (gnt_n[2:0] != 3'b000);
      byte_req      <= (state_n == SETUP) && gnt_n[3];
      timeout_err   <= (state_n == ABORT);
    end
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: a reactive host drives the handshakes, a
// transaction-level reference predicts every output each cycle, and directed
// scenarios pin the reference with hand-computed counts and cycle distances.
module tb_bus_xfer_sequencer;

  localparam int BYTES = 2;
  localparam int TMO   = 16;

  localparam int PH_IDLE    = 0;
  localparam int PH_OFFER   = 1;
  localparam int PH_STROBE  = 2;
  localparam int PH_RELEASE = 3;
  localparam int PH_DONE    = 4;
  localparam int PH_ABORT   = 5;

  logic        clk;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic        ard_receive_ready = 1'b0;
  logic        ard_data_ready = 1'b0;
  logic [7:0]  in_bus = 8'h00;
  logic [3:0]  gnt, done;
  logic        busy, bus_pc, bus_mar, bus_mdr;
  logic        pc_shift_out, mar_shift_out, mdr_shift_out, mdr_shift_in;
  logic        byte_valid, byte_req, timeout_err;
  logic [18:0] dut_vec;
  logic [3:0]  strobe_v;

  bus_xfer_sequencer #(.BYTES(BYTES), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .ard_receive_ready(ard_receive_ready), .ard_data_ready(ard_data_ready),
    .gnt(gnt), .done(done), .busy(busy),
    .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr),
    .pc_shift_out(pc_shift_out), .mar_shift_out(mar_shift_out),
    .mdr_shift_out(mdr_shift_out), .mdr_shift_in(mdr_shift_in),
    .byte_valid(byte_valid), .byte_req(byte_req), .timeout_err(timeout_err)
  );

  assign dut_vec  = {gnt, done, busy, bus_pc, bus_mar, bus_mdr,
                     pc_shift_out, mar_shift_out, mdr_shift_out, mdr_shift_in,
                     byte_valid, byte_req, timeout_err};
  assign strobe_v = {mdr_shift_in, mdr_shift_out, mar_shift_out, pc_shift_out};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  // Cycle index, advanced on every rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: who owns the bus, which step of the byte protocol it is in,
  // how many bytes are finished and how long the host has kept it waiting.
  int m_owner = -1;
  int m_step  = PH_IDLE;
  int m_byte  = 0;
  int m_wait  = 0;

  function automatic int pick(input logic [3:0] r);
    int order [4];
    order = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      if (r[order[i]]) return order[i];
    end
    return -1;
  endfunction

  function automatic logic [18:0] model_vec(input int owner, input int step);
    logic [3:0] g;
    logic       live;
    g    = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    live = (step == PH_OFFER) || (step == PH_STROBE) || (step == PH_RELEASE);
    return {g, (step == PH_DONE) ? g : 4'b0000, step != PH_IDLE,
            live && owner == 0, live && owner == 1, live && owner == 2,
            step == PH_STROBE && owner == 0, step == PH_STROBE && owner == 1,
            step == PH_STROBE && owner == 2, step == PH_STROBE && owner == 3,
            step == PH_OFFER && owner < 3, step == PH_OFFER && owner == 3,
            step == PH_ABORT};
  endfunction

  // Reference update from the inputs seen at each rising edge.
  initial forever begin
    logic host_rdy;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_owner = -1;
      m_step  = PH_IDLE;
      m_byte  = 0;
      m_wait  = 0;
    end else begin
      host_rdy = (m_owner == 3) ? ard_data_ready : ard_receive_ready;
      case (m_step)
        PH_IDLE: begin
          m_owner = pick(req);
          if (m_owner >= 0) begin
            m_step = PH_OFFER;
            m_byte = 0;
            m_wait = 0;
          end
        end
        PH_OFFER: begin
          if (host_rdy)              m_step = PH_STROBE;
          else if (m_wait == TMO - 1) m_step = PH_ABORT;
          else                       m_wait++;
        end
        PH_STROBE: begin
          m_step = PH_RELEASE;
          m_wait = 0;
        end
        PH_RELEASE: begin
          if (!host_rdy) begin
            if (m_byte == BYTES - 1) begin
              m_step = PH_DONE;
            end else begin
              m_byte++;
              m_wait = 0;
              m_step = PH_OFFER;
            end
          end else if (m_wait == TMO - 1) begin
            m_step = PH_ABORT;
          end else begin
            m_wait++;
          end
        end
        default: begin
          m_step  = PH_IDLE;
          m_owner = -1;
        end
      endcase
    end
  end

  int            cnt_strobe [4];
  int            cnt_done [4];
  int            cnt_sel [3];
  int            cnt_tmo = 0;
  int            cnt_busy = 0;
  int            cnt_breq = 0;
  int            ev_cnt = 0;
  int            first_gnt_cyc = -1;
  int            first_valid_cyc = -1;
  int            tmo_cyc = -1;
  int            done_order [$];
  int            strobe_cyc [$];
  logic [7:0]    cap [$];

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      cnt_strobe[k] = 0;
      cnt_done[k]   = 0;
    end
    for (int k = 0; k < 3; k++) cnt_sel[k] = 0;
    cnt_tmo         = 0;
    cnt_busy        = 0;
    cnt_breq        = 0;
    ev_cnt          = 0;
    first_gnt_cyc   = -1;
    first_valid_cyc = -1;
    tmo_cyc         = -1;
    done_order.delete();
    strobe_cyc.delete();
    cap.delete();
  endtask

  // Compare process: every falling edge, DUT outputs against the reference,
  // structural one-hot rules, and event tallies for the scenario checks.
  initial forever begin
    logic onehot_ok;
    @(negedge clk);
    checkOutput("cycle_outputs", int'(dut_vec), int'(model_vec(m_owner, m_step)));
    onehot_ok = $onehot0(gnt) && $onehot0({bus_pc, bus_mar, bus_mdr}) && $onehot0(strobe_v);
    checkOutput("one_hot_rules", int'(onehot_ok), 1);
    for (int k = 0; k < 4; k++) begin
      if (strobe_v[k]) cnt_strobe[k]++;
      if (done[k]) begin
        cnt_done[k]++;
        done_order.push_back(k);
        ev_cnt++;
      end
    end
    if (strobe_v != 4'b0000) strobe_cyc.push_back(cyc);
    if (bus_pc)  cnt_sel[0]++;
    if (bus_mar) cnt_sel[1]++;
    if (bus_mdr) cnt_sel[2]++;
    if (busy) cnt_busy++;
    if (byte_req) cnt_breq++;
    if (mdr_shift_in) cap.push_back(in_bus);
    if (gnt != 4'b0000 && first_gnt_cyc < 0) first_gnt_cyc = cyc;
    if ((byte_valid || byte_req) && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (timeout_err) begin
      cnt_tmo++;
      tmo_cyc = cyc;
      ev_cnt++;
    end
  end

  logic       host_on = 1'b0;
  int         rise_dly = 1;
  int         fall_dly = 1;
  int         wait_cnt = 0;
  int         hold_cnt = 0;
  logic       hold_on = 1'b0;
  logic [7:0] in_bytes [$];

  // Host and requesters: react to the DUT shortly after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    req = req & ~done;
    if (timeout_err) req = 4'b0000;
    if (host_on) begin
      if (byte_valid || byte_req) begin
        wait_cnt++;
        if (wait_cnt >= rise_dly && !ard_receive_ready && !ard_data_ready) begin
          if (byte_req) begin
            ard_data_ready = 1'b1;
            if (in_bytes.size() > 0) in_bus = in_bytes.pop_front();
          end else begin
            ard_receive_ready = 1'b1;
          end
        end
      end else begin
        wait_cnt = 0;
      end
      if (strobe_v != 4'b0000) begin
        hold_on  = 1'b1;
        hold_cnt = 0;
      end else if (hold_on) begin
        hold_cnt++;
        if (hold_cnt >= fall_dly) begin
          ard_receive_ready = 1'b0;
          ard_data_ready    = 1'b0;
          hold_on           = 1'b0;
        end
      end
    end
  end

  int req_cyc = 0;

  task automatic applyStimulus(input logic [3:0] r, input int rise, input int fall, input logic on);
    @(posedge clk);
    #1;
    rise_dly = rise;
    fall_dly = fall;
    host_on  = on;
    wait_cnt = 0;
    hold_on  = 1'b0;
    req      = r;
    req_cyc  = cyc;
  endtask

  task automatic waitEvents(input int n, input int budget, input string name);
    int k = 0;
    while (ev_cnt < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput(name, int'(ev_cnt >= n), 1);
  endtask

  task automatic waitStrobes(input int idx, input int n, input int budget, input string name);
    int k = 0;
    while (cnt_strobe[idx] < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput(name, int'(cnt_strobe[idx] >= n), 1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Directed scenarios.
  initial begin
    int v;
    int exp_order [4];
    exp_order = '{1, 2, 3, 0};
    clear_stats();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 checkOutput("reset_held", int'(dut_vec), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 checkOutput("reset_state", int'(dut_vec), 0);

    $display("[TB] single pc_out transaction");
    clear_stats();
    applyStimulus(4'b0001, 2, 2, 1'b1);
    waitEvents(1, 200, "pc_finish");
    settle();
    checkOutput("pc_grant_latency", first_gnt_cyc - req_cyc, 1);
    checkOutput("pc_strobes", cnt_strobe[0], 2);
    checkOutput("pc_done", cnt_done[0], 1);
    checkOutput("pc_mar_sel", cnt_sel[1], 0);
    checkOutput("pc_mdr_sel", cnt_sel[2], 0);

    $display("[TB] arbitration of all four requesters");
    clear_stats();
    applyStimulus(4'b1111, 1, 1, 1'b1);
    waitEvents(4, 600, "arb_finish");
    settle();
    for (int k = 0; k < 4; k++) begin
      v = (done_order.size() > k) ? done_order[k] : -1;
      checkOutput($sformatf("arb_order_%0d", k), v, exp_order[k]);
    end
    checkOutput("arb_total_strobes",
                cnt_strobe[0] + cnt_strobe[1] + cnt_strobe[2] + cnt_strobe[3], 4 * BYTES);

    $display("[TB] mdr_in transaction");
    clear_stats();
    in_bytes.push_back(8'hA5);
    in_bytes.push_back(8'h3C);
    applyStimulus(4'b1000, 1, 2, 1'b1);
    waitEvents(1, 200, "mdr_in_finish");
    settle();
    v = (cap.size() > 0) ? int'(cap[0]) : -1;
    checkOutput("mdr_in_byte0", v, 'hA5);
    v = (cap.size() > 1) ? int'(cap[1]) : -1;
    checkOutput("mdr_in_byte1", v, 'h3C);
    checkOutput("mdr_in_strobes", cnt_strobe[3], 2);
    checkOutput("mdr_in_selects", cnt_sel[0] + cnt_sel[1] + cnt_sel[2], 0);
    checkOutput("mdr_in_byte_req_seen", int'(cnt_breq >= 2), 1);
    checkOutput("mdr_in_done", cnt_done[3], 1);

    $display("[TB] host never answers");
    clear_stats();
    applyStimulus(4'b0010, 1, 1, 1'b0);
    waitEvents(1, 100, "timeout_finish");
    @(negedge clk);
    #1 checkOutput("timeout_busy_after", int'(busy), 0);
    settle();
    checkOutput("timeout_distance", tmo_cyc - first_valid_cyc, TMO);
    checkOutput("timeout_pulses", cnt_tmo, 1);
    checkOutput("timeout_strobes",
                cnt_strobe[0] + cnt_strobe[1] + cnt_strobe[2] + cnt_strobe[3], 0);
    checkOutput("timeout_done", cnt_done[1], 0);

    $display("[TB] host holds receive ready");
    clear_stats();
    applyStimulus(4'b0010, 1, 10, 1'b1);
    waitEvents(1, 300, "stuck_finish");
    settle();
    v = (strobe_cyc.size() > 1) ? strobe_cyc[1] - strobe_cyc[0] : -1;
    checkOutput("stuck_strobe_gap", v, 12);
    checkOutput("stuck_strobes", cnt_strobe[1], 2);
    checkOutput("stuck_done", cnt_done[1], 1);
    checkOutput("stuck_no_timeout", cnt_tmo, 0);

    $display("[TB] reset during a transfer");
    clear_stats();
    applyStimulus(4'b0010, 1, 3, 1'b1);
    waitStrobes(1, 2, 100, "reset_reach_last_byte");
    @(posedge clk);
    #3;
    rst = 1'b0;
    req = 4'b0000;
    host_on = 1'b0;
    ard_receive_ready = 1'b0;
    ard_data_ready = 1'b0;
    #1 checkOutput("reset_async", int'(dut_vec), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    clear_stats();
    repeat (20) @(negedge clk);
    #1;
    checkOutput("reset_after_busy", cnt_busy, 0);
    checkOutput("reset_after_events", ev_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Safety net in case a scenario stalls beyond every bounded wait.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
Sequences and arbitrates the shared 8-bit serial off-chip bus between the core's PC, MAR and MDR shift registers and the host microcontroller. It grants one requester at a time and moves each 16-bit value as BYTES byte transfers, high byte first. Each byte uses a four-phase ready handshake with the host. It drives the one-hot bus selects (bus_pc/bus_mar/bus_mdr), the shift strobes of the selected shift register, and a per-requester done pulse back to the control FSM.

Parameters:
BYTES, 2, bytes per transaction (1..4)
TIMEOUT, 1024, max cycles waiting on any host handshake edge; 0 disables timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
req  in  4  transaction requests, level; [0] pc_out, [1] mar_out, [2] mdr_out, [3] mdr_in
ard_receive_ready  in  1  host has captured current outbound byte (level)
ard_data_ready  in  1  host has placed inbound byte on in_bus (level)
gnt  out  4  one-hot current grant, same bit mapping as req
done  out  4  one-cycle completion pulse, same bit mapping
busy  out  1  high whenever state != IDLE
bus_pc, bus_mar, bus_mdr  out  1 each  one-hot out_bus source select
pc_shift_out, mar_shift_out, mdr_shift_out  out  1 each  one-cycle shift strobe to source register
mdr_shift_in  out  1  one-cycle strobe, MDR captures in_bus
byte_valid  out  1  outbound byte is stable on out_bus
byte_req  out  1  block requests an inbound byte
timeout_err  out  1  one-cycle pulse, transaction aborted

Behaviour:
- Reset (async, rst=0): state IDLE, byte_cnt=0, timer=0, all outputs 0. Asserting reset mid-transaction aborts immediately. No done or timeout_err is produced for the aborted transaction.
- Moore outputs, decoded from registered state/grant only.
- States: IDLE, SETUP, STROBE, RELEASE, DONE, ABORT.
- IDLE: req sampled only here. Fixed priority mar_out > mdr_out > mdr_in > pc_out. Winner is registered into gnt; go to SETUP with byte_cnt=0 and timer=0. If req=0, stay in IDLE.
- Latency: req high at edge N gives gnt and select high from cycle N+1.
- SETUP:
  - Outbound grants: the matching bus_x=1 and byte_valid=1.
  - mdr_in: byte_req=1; all bus selects stay 0.
  - Outbound grants wait for ard_receive_ready=1; mdr_in waits for ard_data_ready=1. The non-matching ready input is ignored.
  - On the awaited ready, go to STROBE.
- STROBE (exactly 1 cycle): pulse the granted shift strobe (x_shift_out, or mdr_shift_in). Select stays high; byte_valid/byte_req drop to 0. Then go to RELEASE with timer=0.
- RELEASE: select stays high. Wait for the awaited ready input to return to 0; no further strobe while it stays high.
  - If byte_cnt==BYTES-1, go to DONE.
  - Otherwise byte_cnt+1, timer=0, go to SETUP.
- DONE (1 cycle): done[g]=1, gnt still held, selects 0. Then go to IDLE.
  - The IDLE cycle always re-arbitrates.
  - A req still high after done starts a new transaction. Requesters drop req on the cycle done is seen.
- Timeout: timer counts every cycle in SETUP and RELEASE, saturating. If TIMEOUT!=0 and timer reaches TIMEOUT-1 without the awaited edge, go to ABORT.
- ABORT (1 cycle): timeout_err=1, no done, selects 0. Then go to IDLE.
- Invariants:
  - At most one of bus_pc/bus_mar/bus_mdr is high.
  - At most one strobe is high in any cycle.
  - Exactly BYTES strobes per completed transaction.
  - gnt is zero in IDLE.
- Width: byte_cnt is clog2(BYTES) bits, minimum 1. timer is clog2(TIMEOUT+1) bits.

Test Plan:
1. Single pc_out: req=4'b0001. Host asserts ard_receive_ready 2 cycles after byte_valid and drops it 2 cycles after the strobe. Required: bus_pc high from cycle after req through last RELEASE, exactly 2 pc_shift_out pulses, one done[0] pulse, bus_mar/bus_mdr never high.
2. Arbitration: req=4'b1111 held, each requester dropping its bit on its done. Required grant order mar_out, mdr_out, mdr_in, pc_out; done pulses in that order; gnt always one-hot or zero.
3. mdr_in: req=4'b1000, host drives in_bus=8'hA5 then 8'h3C with ard_data_ready handshakes. Required: byte_req high in each SETUP, 2 mdr_shift_in pulses aligned with each byte, no bus select ever high, done[3] pulse.
4. Timeout: TIMEOUT=16, req=4'b0010, host never asserts ready. Required: timeout_err pulses once, 16 cycles after SETUP entry; zero strobes; no done; busy=0 the next cycle.
5. Stuck ready: host holds ard_receive_ready high after the first strobe for 10 cycles. Required: block stays in RELEASE with no second strobe; it resumes only after ready falls and completes normally.
6. Reset mid-op: assert rst=0 while in RELEASE of byte 1 of mar_out. Required: all outputs 0 asynchronously (same cycle); after rst=1 with req=0, busy stays 0 and no done or timeout_err appears.
